program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/loader_pkg.sv | 19 +
 rtl/rise_detect.sv | 23 ++
 rtl/program_loader.sv | 138 +++++++++++++
 tb/tb_program_loader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
package loader_pkg;

    // Loader control states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    // Bit positions within the sticky error vector
    localparam int ERR_OVF = 0;
    localparam int ERR_TMO = 1;

    // MIPS instruction word width
    localparam int INSTR_W = 32;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector: rise is high in the cycle d is high
// after having been low in the previous cycle.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic prev;

    // Remember last cycle's level of d
    always_ff @(posedge clk) begin
        if (rst) prev <= 1'b0;
        else     prev <= d;
    end

    // Edge is current high with previous low
    always_comb begin
        rise = d & ~prev;
    end

endmodule

// File: rtl/program_loader.sv
// Streams a host program into processor instruction memory, releases the
// processor, waits for completion (or timeout) and captures its output.
module program_loader
    import loader_pkg::*;
#(
    parameter  int IMEM_DEPTH = 32,
    parameter  int TIMEOUT    = 1024,
    localparam int AW         = $clog2(IMEM_DEPTH),
    localparam int TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               prog_valid,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               prog_last,
    output logic               prog_ready,
    output logic               imem_we,
    output logic [AW-1:0]      imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_run,
    input  logic               cpu_done,
    input  logic signed [7:0]  cpu_out,
    output logic signed [7:0]  result,
    output logic               result_valid,
    output logic               busy,
    output logic [1:0]         error
);

    localparam logic [AW-1:0] ADDR_LAST = AW'(IMEM_DEPTH - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    state_t             state, state_n;
    logic [AW-1:0]      cnt, cnt_n;
    logic [TW-1:0]      tcnt, tcnt_n;
    logic [1:0]         err_n;
    logic signed [7:0]  res_n;
    logic               rv_n;
    logic               done_rise;

    // The detector keeps tracking cpu_done outside RUN, so a level that is
    // already high when RUN begins produces no edge until it falls and rises.
    rise_detect u_done_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (cpu_done),
        .rise (done_rise)
    );

    // State and datapath registers; reset overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            tcnt         <= '0;
            error        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            tcnt         <= tcnt_n;
            error        <= err_n;
            result       <= res_n;
            result_valid <= rv_n;
        end
    end

    // Next-state logic and combinational outputs
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        tcnt_n     = tcnt;
        err_n      = error;
        res_n      = result;
        rv_n       = 1'b0;
        prog_ready = 1'b0;
        imem_we    = 1'b0;
        imem_addr  = cnt;
        imem_wdata = prog_data;
        cpu_run    = 1'b0;
        busy       = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_LOAD;
                    cnt_n   = '0;
                end
            end

            S_LOAD: begin
                prog_ready = 1'b1;
                busy       = 1'b1;
                if (prog_valid) begin
                    imem_we = 1'b1;
                    cnt_n   = cnt + 1'b1;
                    // A last word in the final slot is legal, so it wins
                    // over the overflow check.
                    if (prog_last) begin
                        state_n = S_RUN;
                        tcnt_n  = '0;
                    end else if (cnt == ADDR_LAST) begin
                        err_n[ERR_OVF] = 1'b1;
                        state_n        = S_FAULT;
                    end
                end
            end

            S_RUN: begin
                cpu_run = 1'b1;
                busy    = 1'b1;
                // Completion is checked first so it beats a coincident timeout
                if (done_rise) begin
                    res_n   = cpu_out;
                    rv_n    = 1'b1;
                    state_n = S_IDLE;
                end else if (tcnt == TMO_LAST) begin
                    err_n[ERR_TMO] = 1'b1;
                    state_n        = S_FAULT;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end

            S_FAULT: begin
                if (start) begin
                    err_n   = '0;
                    cnt_n   = '0;
                    state_n = S_LOAD;
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader.
module tb_program_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        prog_valid;
    logic [31:0] prog_data;
    logic        prog_last;
    logic        prog_ready;
    logic        imem_we;
    logic [4:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_run;
    logic        cpu_done;
    logic [7:0]  cpu_out;
    logic [7:0]  result;
    logic        result_valid;
    logic        busy;
    logic [1:0]  error;

    int unsigned n_tests;
    int unsigned n_fail;

    program_loader #(
        .IMEM_DEPTH (32),
        .TIMEOUT    (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .prog_valid   (prog_valid),
        .prog_data    (prog_data),
        .prog_last    (prog_last),
        .prog_ready   (prog_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_run      (cpu_run),
        .cpu_done     (cpu_done),
        .cpu_out      (cpu_out),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .error        (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Run-time guard so the bench can never hang
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic last, input logic [4:0] addr);
        prog_valid = 1'b1;
        prog_data  = d;
        prog_last  = last;
        #1;
        check("we", 32'(imem_we), 32'd1);
        check("addr", 32'(imem_addr), 32'(addr));
        check("wdata", imem_wdata, d);
        tick();
        prog_valid = 1'b0;
        prog_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        start      = 1'b0;
        prog_valid = 1'b0;
        prog_data  = '0;
        prog_last  = 1'b0;
        cpu_done   = 1'b0;
        cpu_out    = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_run", 32'(cpu_run), 32'd0);
        check("rst_ready", 32'(prog_ready), 32'd0);
        check("rst_err", 32'(error), 32'd0);
        check("rst_res", 32'(result), 32'd0);
        check("rst_rv", 32'(result_valid), 32'd0);

        // Basic three-word load and run
        pulse_start();
        check("load_ready", 32'(prog_ready), 32'd1);
        check("load_busy", 32'(busy), 32'd1);
        check("load_run", 32'(cpu_run), 32'd0);
        send(32'h2008_0005, 1'b0, 5'd0);
        send(32'h2009_0003, 1'b0, 5'd1);
        send(32'h0109_5020, 1'b1, 5'd2);
        check("run_run", 32'(cpu_run), 32'd1);
        check("run_ready", 32'(prog_ready), 32'd0);
        check("run_busy", 32'(busy), 32'd1);
        cpu_out  = 8'd8;
        cpu_done = 1'b1;
        tick();
        check("done_res", 32'(result), 32'h08);
        check("done_rv", 32'(result_valid), 32'd1);
        check("done_run", 32'(cpu_run), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        tick();
        check("rv_pulse", 32'(result_valid), 32'd0);
        check("res_hold", 32'(result), 32'h08);
        cpu_done = 1'b0;

        // Overflow: 32 words with no last marker
        pulse_start();
        for (int i = 0; i < 32; i++) begin
            check("ovf_norun", 32'(cpu_run), 32'd0);
            send(32'h1000_0000 + 32'(i), 1'b0, 5'(i));
        end
        check("ovf_err", 32'(error), 32'd1);
        check("ovf_busy", 32'(busy), 32'd0);
        check("ovf_ready", 32'(prog_ready), 32'd0);
        check("ovf_run", 32'(cpu_run), 32'd0);
        prog_valid = 1'b1;
        #1;
        check("fault_nowe", 32'(imem_we), 32'd0);
        tick();
        prog_valid = 1'b0;
        check("ovf_sticky", 32'(error), 32'd1);

        // Timeout with a stuck processor; start in RUN is ignored
        pulse_start();
        check("clr_err", 32'(error), 32'd0);
        check("clr_busy", 32'(busy), 32'd1);
        send(32'hDEAD_0001, 1'b1, 5'd0);
        check("tmo_run0", 32'(cpu_run), 32'd1);
        for (int i = 0; i < 15; i++) begin
            if (i == 5) start = 1'b1;
            tick();
            start = 1'b0;
        end
        check("tmo_run15", 32'(cpu_run), 32'd1);
        check("tmo_err15", 32'(error), 32'd0);
        tick();
        check("tmo_err", 32'(error), 32'd2);
        check("tmo_run", 32'(cpu_run), 32'd0);
        check("tmo_busy", 32'(busy), 32'd0);

        // Completion in the final timeout cycle wins
        pulse_start();
        send(32'hDEAD_0002, 1'b1, 5'd0);
        for (int i = 0; i < 15; i++) tick();
        cpu_out  = 8'h11;
        cpu_done = 1'b1;
        tick();
        check("tie_err", 32'(error), 32'd0);
        check("tie_res", 32'(result), 32'h11);
        check("tie_rv", 32'(result_valid), 32'd1);
        check("tie_busy", 32'(busy), 32'd0);

        // cpu_done already high on RUN entry is ignored
        pulse_start();
        send(32'hDEAD_0003, 1'b1, 5'd0);
        cpu_out = 8'h55;
        tick();
        tick();
        tick();
        check("hi_run", 32'(cpu_run), 32'd1);
        check("hi_rv", 32'(result_valid), 32'd0);
        check("hi_hold", 32'(result), 32'h11);
        cpu_done = 1'b0;
        tick();
        cpu_done = 1'b1;
        cpu_out  = 8'hFD;
        tick();
        check("neg_res", 32'(result), 32'hFD);
        check("neg_rv", 32'(result_valid), 32'd1);
        check("neg_run", 32'(cpu_run), 32'd0);
        cpu_done = 1'b0;
        tick();
        check("neg_rv_end", 32'(result_valid), 32'd0);

        // Reset mid-load
        pulse_start();
        send(32'hAAAA_0000, 1'b0, 5'd0);
        send(32'hAAAA_0001, 1'b0, 5'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_ready", 32'(prog_ready), 32'd0);
        check("mrst_we", 32'(imem_we), 32'd0);
        check("mrst_run", 32'(cpu_run), 32'd0);
        check("mrst_err", 32'(error), 32'd0);
        check("mrst_res", 32'(result), 32'd0);
        check("mrst_rv", 32'(result_valid), 32'd0);
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_prio", 32'(busy), 32'd0);

        // Reload from address 0 with gapped valid
        pulse_start();
        send(32'hBBBB_0000, 1'b0, 5'd0);
        prog_valid = 1'b0;
        #1;
        check("gap_we0", 32'(imem_we), 32'd0);
        check("gap_ready0", 32'(prog_ready), 32'd1);
        tick();
        send(32'hBBBB_0001, 1'b0, 5'd1);
        #1;
        check("gap_we1", 32'(imem_we), 32'd0);
        tick();
        send(32'hBBBB_0002, 1'b1, 5'd2);
        check("gap_run", 32'(cpu_run), 32'd1);
        cpu_out  = 8'h7F;
        cpu_done = 1'b1;
        tick();
        check("gap_res", 32'(result), 32'h7F);
        check("gap_rv", 32'(result_valid), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
